// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - packs N_BYTES received bytes into a word on a valid/ready register; optional idle timeout via BWA_TIMEOUT_EN
module byte_word_assembler #(
  parameter int N_BYTES     = 8,
  parameter int CNT_W       = $clog2(N_BYTES),
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           dato,
  input  logic                 rx_flat,
  input  logic                 msb_first,
  input  logic                 word_ready,
  input  logic                 clr_ovf,
  output logic [N_BYTES*8-1:0] data_comple,
  output logic                 flat_comple,
  output logic [CNT_W-1:0]     byte_cnt,
  output logic                 overflow,
  output logic                 timeout_flat
);

  localparam int W = N_BYTES * 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

  // Reject illegal parameter sets at elaboration time.
  if (N_BYTES < 2 || N_BYTES > 32 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("byte_word_assembler: N_BYTES must be 2..32 and TIMEOUT_CYC >= 2");
  end

  logic [W-1:0]     buffer;
  logic [W-1:0]     next_word;
  logic             order_q;
  logic             order_eff;
  logic [CNT_W-1:0] pos;
  logic             last_byte;
  logic             reg_free;
  logic             timeout_hit;

  // Slot for the incoming byte, the word including it, and the handshake qualifiers.
  always_comb begin
    order_eff = (byte_cnt == '0) ? msb_first : order_q;
    pos       = order_eff ? (LAST - byte_cnt) : byte_cnt;
    next_word = buffer;
    next_word[{pos, 3'b000} +: 8] = dato;
    last_byte = rx_flat && (byte_cnt == LAST);
    reg_free  = !flat_comple || word_ready;
  end

`ifdef BWA_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = !rx_flat && (byte_cnt != '0) && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // Count consecutive idle cycles while a partial word is pending; any strobe restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (rx_flat || timeout_hit || byte_cnt == '0) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Byte collection: shift buffer, byte counter and the per-word byte order latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer   <= '0;
      byte_cnt <= '0;
      order_q  <= 1'b0;
    end else if (rx_flat) begin
      if (byte_cnt == '0) begin
        order_q <= msb_first;
      end
      if (last_byte) begin
        buffer   <= '0;
        byte_cnt <= '0;
      end else begin
        buffer   <= next_word;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end else if (timeout_hit) begin
      buffer   <= '0;
      byte_cnt <= '0;
    end
  end

  // Output register: load on completion when free, drop flat_comple on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_comple <= '0;
      flat_comple <= 1'b0;
    end else if (last_byte && reg_free) begin
      data_comple <= next_word;
      flat_comple <= 1'b1;
    end else if (flat_comple && word_ready) begin
      flat_comple <= 1'b0;
    end
  end

  // Sticky overflow when a completed word finds the register occupied; set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (last_byte && !reg_free) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // One-cycle pulse marking a discarded partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_flat <= 1'b0;
    end else begin
      timeout_flat <= timeout_hit;
    end
  end

endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Parametrised successor to the fixed 8-byte UART word collector.
- Packs N_BYTES serial-receiver bytes into one N_BYTES*8-bit word and presents it on a valid/ready output register.
- Adds the following, which the previous collector did not have:
  - runtime byte order;
  - backpressure with a one-word holding register;
  - a sticky overflow flag;
  - a fill-level output.
- Sits between the UART RX byte strobe and the downstream word consumer (e.g. weight/operand loader).

Parameters:
- N_BYTES, 8, bytes per assembled word; legal values 2..32.
- CNT_W, $clog2(N_BYTES), width of the byte counter; derived, do not override.
- TIMEOUT_CYC, 1000000, idle-cycle limit for the partial-word timeout; used only when BWA_TIMEOUT_EN is defined; legal values >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dato  in  8  received byte; valid when rx_flat = 1.
- rx_flat  in  1  one-cycle byte strobe.
- msb_first  in  1  byte order; 0 = first byte to bits [7:0], 1 = first byte to the top byte.
- word_ready  in  1  consumer accepts the word when word_ready = 1 and flat_comple = 1.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- data_comple  out  N_BYTES*8  assembled word.
- flat_comple  out  1  word valid; held until accepted.
- byte_cnt  out  CNT_W  bytes collected in the current partial word.
- overflow  out  1  sticky flag: a completed word was dropped.
- timeout_flat  out  1  one-cycle pulse: a partial word was discarded by timeout.

Behaviour:
- Reset (asynchronous, rst = 0): every output goes to 0, including data_comple, flat_comple, byte_cnt, overflow and timeout_flat. The internal shift buffer, the latched byte order and the idle counter also go to 0.
- Byte order latch: msb_first is sampled when byte_cnt = 0 and rx_flat = 1, and held for the whole word. Changing msb_first mid-word has no effect on that word.
- Byte placement: the byte arriving at position i (0-based) goes to:
  - bits [8i+7:8i] when the latched order is 0;
  - bits [8(N_BYTES-1-i)+7 : 8(N_BYTES-1-i)] when the latched order is 1.
- Counting:
  - Each rx_flat increments byte_cnt.
  - The final byte (rx_flat with byte_cnt = N_BYTES-1) completes the word, and byte_cnt returns to 0 in the same edge.
  - rx_flat on consecutive cycles is legal.
- Output register is free when flat_comple = 0, or when flat_comple = 1 and word_ready = 1 in the current cycle.
- Completion with the register free:
  - On the next edge, data_comple is loaded with the full word (the final byte included) and flat_comple = 1.
  - Latency is one cycle from the final strobe.
  - Back-to-back handover with no bubble is required.
- Completion with the register not free:
  - The new word is dropped.
  - data_comple and flat_comple keep their current values.
  - overflow goes to 1 on the next edge.
  - byte_cnt still returns to 0.
- Acceptance: flat_comple = 1 and word_ready = 1 with no completion in that cycle gives flat_comple = 0 on the next edge. data_comple holds its last value.
- overflow: cleared by clr_ovf = 1. If a new overflow and clr_ovf occur in the same cycle, set wins.
- While flat_comple = 1: data_comple must remain stable.
- rx_flat = 0: no state change except the idle counter.
- N_BYTES = 2: the counter is 1 bit wide and the same rules apply.

Optional Feature:
- Macro: BWA_TIMEOUT_EN.
- Defined:
  - The idle counter increments each cycle that byte_cnt != 0 and rx_flat = 0, and resets on any rx_flat.
  - When it reaches TIMEOUT_CYC-1 (i.e. after TIMEOUT_CYC consecutive idle cycles), the partial word is discarded: byte_cnt = 0, the buffer is cleared, and timeout_flat pulses for one cycle.
  - rx_flat arriving in that same cycle wins: the byte is accepted and there is no timeout.
- Undefined:
  - No idle counter is built.
  - timeout_flat is tied to 0.
  - A partial word waits indefinitely.

Test Plan:
- LSB order (msb_first = 0): bytes 01..08 strobed on consecutive cycles, word_ready = 1 → one cycle after the 8th strobe data_comple = 0x0807060504030201 and flat_comple = 1; byte_cnt is 0 after the 8th strobe.
- MSB order: same bytes with msb_first = 1, toggling msb_first to 0 after byte 3 → data_comple = 0x0102030405060708.
- Backpressure: word_ready = 0, send word A = 01..08, then word B = 11..18 → data_comple stays 0x0807060504030201 and overflow = 1. Then clr_ovf = 1 with word_ready = 1 → overflow = 0 and flat_comple = 0.
- Handover on accept: word A pending; word_ready = 1 in the same cycle word B's final byte arrives → next cycle data_comple = 0x1817161514131211, flat_comple = 1, overflow = 0.
- Reset mid-word: 3 bytes sent, rst pulsed low → all outputs 0. Then bytes 21..28 → 0x2827262524232221.
- Timeout (BWA_TIMEOUT_EN, TIMEOUT_CYC = 16; also N_BYTES = 4 build): 2 bytes, then 16 idle cycles → timeout_flat pulses and byte_cnt = 0. Then AA BB CC DD → data_comple = 0xDDCCBBAA.
